fp_writeback_arbiter: RTL

FP_WRITEBACK_ARBITER -- requirements
Module: fp_writeback_arbiter

---
 rtl/fp_writeback_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/fp_writeback_arbiter.sv
// rtl/fp_writeback_arbiter.sv - FP register writeback arbiter with pending scoreboard
// Merges MEM load writes and FPU results into one RF write port and tracks in-flight destinations.
module fp_writeback_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic [ADDR_W-1:0] issue_src1,
  input  logic [ADDR_W-1:0] issue_src2,
  input  logic              issue_reads_fp,
  output logic              issue_stall,
  input  logic              mem_wr_valid,
  input  logic [ADDR_W-1:0] mem_wr_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  input  logic              fpu_valid,
  input  logic [ADDR_W-1:0] fpu_addr,
  input  logic [DATA_W-1:0] fpu_data,
  output logic              fpu_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [ADDR_W:0]   pending_count
);

  localparam int NREG = 1 << ADDR_W;
  localparam int CW   = ADDR_W + 1;

  typedef enum logic {EMPTY, HELD} state_t;

  state_t            state, state_next;
  logic [NREG-1:0]   pending, pending_next;
  logic [CW-1:0]     count_next;
  logic [ADDR_W-1:0] buf_addr, buf_addr_next;
  logic [DATA_W-1:0] buf_data, buf_data_next;
  logic              fpu_acc;
  logic              sel_valid;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              issue_fire;

  assign issue_stall = issue_valid & (pending[issue_dest] |
                       (issue_reads_fp & (pending[issue_src1] | pending[issue_src2])));
  assign issue_fire  = issue_valid & ~issue_stall;

  // Write-port selection: mem always wins; a displaced FPU result parks in the skid buffer.
  always_comb begin
    state_next    = state;
    buf_addr_next = buf_addr;
    buf_data_next = buf_data;
    sel_valid     = 1'b0;
    sel_addr      = mem_wr_addr;
    sel_data      = mem_wr_data;
    fpu_ready     = (state == EMPTY);
    fpu_acc       = fpu_valid & fpu_ready;
    if (mem_wr_valid) begin
      sel_valid = 1'b1;
      if (fpu_acc) begin
        buf_addr_next = fpu_addr;
        buf_data_next = fpu_data;
        state_next    = HELD;
      end
    end else if (state == HELD) begin
      sel_valid  = 1'b1;
      sel_addr   = buf_addr;
      sel_data   = buf_data;
      state_next = EMPTY;
    end else if (fpu_acc) begin
      sel_valid = 1'b1;
      sel_addr  = fpu_addr;
      sel_data  = fpu_data;
    end
  end

  // Clear before set so a same-edge issue to the retiring register keeps its bit.
  always_comb begin
    pending_next = pending;
    if (sel_valid)  pending_next[sel_addr]   = 1'b0;
    if (issue_fire) pending_next[issue_dest] = 1'b1;
    count_next = '0;
    for (int i = 0; i < NREG; i++) begin
      count_next = count_next + CW'(pending_next[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= EMPTY;
      pending       <= '0;
      pending_count <= '0;
      buf_addr      <= '0;
      buf_data      <= '0;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
    end else begin
      state         <= state_next;
      pending       <= pending_next;
      pending_count <= count_next;
      buf_addr      <= buf_addr_next;
      buf_data      <= buf_data_next;
      rf_we         <= sel_valid;
      if (sel_valid) begin
        rf_waddr <= sel_addr;
        rf_wdata <= sel_data;
      end
    end
  end

endmodule
